// File: rtl/xor_check_pkg.sv
// Shared types and constants for the XOR truth-table checker.
package xor_check_pkg;

    localparam int NUM_VECTORS = 4;
    localparam int VEC_W       = $clog2(NUM_VECTORS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic logic xor_expected(input logic a, input logic b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/xor_tt_checker_hold_timer.sv
// Hold timer: counts cycles since the last clear; expire flags the last hold cycle.
module hold_timer #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != CW'(CYCLES)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == CW'(CYCLES - 1));

endmodule

// File: rtl/xorgate.sv
// Two-input XOR gate: the device exercised by the truth-table checker.
module xorgate (
    input  logic a,
    input  logic b,
    output logic c
);

    assign c = a ^ b;

endmodule

// File: rtl/xor_tt_checker.sv
// Walks an XOR gate through its truth table and records mismatches per vector.
// Optional mismatch counter port err_cnt is built only when XOR_CHECK_ERRCNT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start, gate inputs low
// DRIVE  | vector applied, waiting HOLD_CYCLES for the gate to settle
// SAMPLE | compare c with expected value, advance or finish
// DONE   | results held until next start
module xor_tt_checker
    import xor_check_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   a,
    output logic                   b,
    input  logic                   c,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_VECTORS-1:0] fail_mask,
    output logic [VEC_W-1:0]       vec_idx
`ifdef XOR_CHECK_ERRCNT_EN
    ,
    output logic [2:0]             err_cnt
`endif
);

    state_e                 state_q, state_d;
    logic [VEC_W-1:0]       vec_q, vec_d;
    logic [NUM_VECTORS-1:0] fail_q, fail_d;
    logic                   timer_clear;
    logic                   timer_expire;
    logic                   mismatch;
    logic                   launch;

    hold_timer #(
        .CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .expire (timer_expire)
    );

    assign launch   = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign mismatch = (c != xor_expected(vec_q[VEC_W-1], vec_q[0]));

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        fail_d      = fail_q;
        timer_clear = (state_q != DRIVE);
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    vec_d   = '0;
                    fail_d  = '0;
                end
            end
            DRIVE: begin
                if (timer_expire) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    fail_d[vec_q] = 1'b1;
                end
                if (vec_q == VEC_W'(NUM_VECTORS - 1)) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + VEC_W'(1);
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            fail_q  <= fail_d;
        end
    end

`ifdef XOR_CHECK_ERRCNT_EN
    localparam logic [2:0] ERR_MAX = 3'(NUM_VECTORS);

    logic [2:0] err_q, err_d;

    // Saturates at the vector count so it can never wrap.
    always_comb begin
        err_d = err_q;
        if (launch) begin
            err_d = '0;
        end else if ((state_q == SAMPLE) && mismatch && (err_q < ERR_MAX)) begin
            err_d = err_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    logic unused_launch;
    assign unused_launch = launch;
`endif

    assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = done && (fail_q == '0);
    assign a         = busy && vec_q[VEC_W-1];
    assign b         = busy && vec_q[0];
    assign fail_mask = fail_q;
    assign vec_idx   = vec_q;

endmodule

// File: tb/tb_xor_tt_checker.sv
// Directed bench: two checkers (HOLD_CYCLES 2 and 1) each driving an xorgate with fault injection on c.
module tb_xor_tt_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_all, rst_v, start_v, dsel;
    int   fault_mode;
    int   checks   = 0;
    int   failures = 0;

    logic rst2, start2, rst1, start1;
    assign rst2   = rst_all | (rst_v & ~dsel);
    assign start2 = start_v & ~dsel;
    assign rst1   = rst_all | (rst_v & dsel);
    assign start1 = start_v & dsel;

    logic       a2, b2, c2, g2, busy2, done2, pass2;
    logic [3:0] fail2;
    logic [1:0] vec2;
    logic       a1, b1, c1, g1, busy1, done1, pass1;
    logic [3:0] fail1;
    logic [1:0] vec1;
`ifdef XOR_CHECK_ERRCNT_EN
    logic [2:0] err2, err1, oerr;
`endif

    xorgate u_gate2 (.a(a2), .b(b2), .c(g2));
    xorgate u_gate1 (.a(a1), .b(b1), .c(g1));

    assign c2 = (fault_mode == 2) ? 1'b0 :
                (fault_mode == 1 && busy2 && vec2 == 2'd2) ? ~g2 : g2;
    assign c1 = (fault_mode == 2) ? 1'b0 :
                (fault_mode == 1 && busy1 && vec1 == 2'd2) ? ~g1 : g1;

    xor_tt_checker #(.HOLD_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2), .c(c2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_mask(fail2), .vec_idx(vec2)
`ifdef XOR_CHECK_ERRCNT_EN
        , .err_cnt(err2)
`endif
    );

    xor_tt_checker #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .c(c1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fail1), .vec_idx(vec1)
`ifdef XOR_CHECK_ERRCNT_EN
        , .err_cnt(err1)
`endif
    );

    logic       oa, ob, oc, obusy, odone, opass;
    logic [3:0] ofail;
    logic [1:0] ovec;
    always_comb begin
        oa    = dsel ? a1    : a2;
        ob    = dsel ? b1    : b2;
        oc    = dsel ? c1    : c2;
        obusy = dsel ? busy1 : busy2;
        odone = dsel ? done1 : done2;
        opass = dsel ? pass1 : pass2;
        ofail = dsel ? fail1 : fail2;
        ovec  = dsel ? vec1  : vec2;
`ifdef XOR_CHECK_ERRCNT_EN
        oerr  = dsel ? err1  : err2;
`endif
    end

    logic [4:0] last_row = 5'h1f;
    always @(negedge clk) begin
        if ({oa, ob, oc, odone, opass} !== last_row) begin
            $display("%8t | %b %b %b | %b    %b", $time, oa, ob, oc, odone, opass);
            last_row <= {oa, ob, oc, odone, opass};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(obusy), 32'(0));
        check({tag, "_done"}, 32'(odone), 32'(0));
        check({tag, "_pass"}, 32'(opass), 32'(0));
        check({tag, "_mask"}, 32'(ofail), 32'(0));
        check({tag, "_a"},    32'(oa),    32'(0));
        check({tag, "_b"},    32'(ob),    32'(0));
        check({tag, "_vec"},  32'(ovec),  32'(0));
`ifdef XOR_CHECK_ERRCNT_EN
        check({tag, "_err"},  32'(oerr),  32'(0));
`endif
    endtask

    task automatic check_result(input string tag, input logic [3:0] exp_mask, input logic [2:0] exp_err);
        check({tag, "_done"}, 32'(odone), 32'(1));
        check({tag, "_busy"}, 32'(obusy), 32'(0));
        check({tag, "_mask"}, 32'(ofail), 32'(exp_mask));
        check({tag, "_pass"}, 32'(opass), 32'(exp_mask == 4'b0000));
`ifdef XOR_CHECK_ERRCNT_EN
        check({tag, "_err"},  32'(oerr),  32'(exp_err));
`endif
    endtask

    // Pulses start; cycle k is the k-th cycle after the edge that sampled start.
    task automatic run(input int hold, input logic [3:0] exp_mask, input logic [2:0] exp_err,
                       input int restart_at, input int rst_at, input string tag);
        int per, last, v;
        per  = hold + 1;
        last = 4 * per + 1;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        for (int k = 1; k <= last; k++) begin
            if (k < last) begin
                v = (k - 1) / per;
                check({tag, "_a"},    32'(oa),    32'(v[1]));
                check({tag, "_b"},    32'(ob),    32'(v[0]));
                check({tag, "_vec"},  32'(ovec),  32'(v[1:0]));
                check({tag, "_busy"}, 32'(obusy), 32'(1));
                check({tag, "_done"}, 32'(odone), 32'(0));
            end else begin
                check_result(tag, exp_mask, exp_err);
            end
            if (k == rst_at) begin
                rst_v = 1'b1;
                tick();
                rst_v = 1'b0;
                check_idle({tag, "_rst"});
                return;
            end
            if (k == restart_at) start_v = 1'b1;
            if (k < last) begin
                tick();
                start_v = 1'b0;
            end
        end
    endtask

    task automatic hold_check(input string tag, input logic [3:0] exp_mask, input logic [2:0] exp_err);
        repeat (3) tick();
        check_result({tag, "_hold"}, exp_mask, exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        $display("    time | a b c | done pass");
        rst_all = 1'b1; rst_v = 1'b0; start_v = 1'b0; dsel = 1'b0; fault_mode = 0;
        repeat (3) tick();
        rst_all = 1'b0;
        check_idle("rst2");
        dsel = 1'b1; #1;
        check_idle("rst1");
        dsel = 1'b0; #1;

        run(2, 4'b0000, 3'd0, 0, 0, "good");
        hold_check("good", 4'b0000, 3'd0);

        fault_mode = 1;
        run(2, 4'b0100, 3'd1, 0, 0, "inv2");
        hold_check("inv2", 4'b0100, 3'd1);

        fault_mode = 2;
        run(2, 4'b0110, 3'd2, 0, 0, "c0");
        fault_mode = 0;

        run(2, 4'b0000, 3'd0, 5, 8, "midrun");
        run(2, 4'b0000, 3'd0, 0, 0, "clean");

        rst_v = 1'b1; start_v = 1'b1;
        tick();
        rst_v = 1'b0; start_v = 1'b0;
        check("rst_start_busy", 32'(obusy), 32'(0));
        check("rst_start_done", 32'(odone), 32'(0));

        dsel = 1'b1; #1;
        fault_mode = 2;
        run(1, 4'b0110, 3'd2, 0, 0, "h1_c0");
        fault_mode = 0;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        check("h1_restart_busy", 32'(obusy), 32'(1));
        check("h1_restart_done", 32'(odone), 32'(0));
        check("h1_restart_mask", 32'(ofail), 32'(0));
        check("h1_restart_vec",  32'(ovec),  32'(0));
        check("h1_restart_a",    32'(oa),    32'(0));
        check("h1_restart_b",    32'(ob),    32'(0));
        repeat (7) tick();
        check("h1_rerun_early",  32'(odone), 32'(0));
        tick();
        check_result("h1_rerun", 4'b0000, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_tt_checker.md
XOR_TT_CHECKER -- requirements
Module: xor_tt_checker

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2: cycles each input vector is held before c is sampled; legal range 1..15.
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  starts a truth-table run; sampled every cycle.
REQ-006 a  output  1  drive to xorgate input a.
REQ-007 b  output  1  drive to xorgate input b.
REQ-008 c  input  1  xorgate output under test.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  high from run completion until the next start or rst.
REQ-011 pass  output  1  valid while done is high: 1 when fail_mask is all zeros.
REQ-012 fail_mask  output  4  bit i set when vector i mismatched.
REQ-013 vec_idx  output  2  index of the vector currently driven.
REQ-014 err_cnt  output  3  mismatch count; present only with XOR_CHECK_ERRCNT_EN.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-016 Vector i SHALL drive a=i[1] and b=i[0], in order 00, 01, 10, 11; expected value is a^b.
REQ-017 IDLE or DONE with start=1: next cycle is DRIVE, vec_idx=0, hold count=0, fail_mask cleared, err_cnt cleared.
REQ-018 DRIVE SHALL last exactly HOLD_CYCLES cycles, then go to SAMPLE.
REQ-019 SAMPLE lasts one cycle and compares c with a^b. A mismatch sets fail_mask[vec_idx] and increments err_cnt; the result is visible on the next cycle.
REQ-020 SAMPLE exit: vec_idx<3 goes to DRIVE with vec_idx+1 and hold count cleared; vec_idx==3 goes to DONE.
REQ-021 a and b SHALL remain stable through DRIVE and SAMPLE of a vector. a=b=0 in IDLE and DONE.
REQ-022 Latency: done SHALL rise exactly 4*(HOLD_CYCLES+1)+1 cycles after the cycle start is sampled.
REQ-023 busy SHALL be 1 in DRIVE and SAMPLE and 0 in IDLE and DONE.
REQ-024 start asserted while busy SHALL be ignored, with no restart and no state change.
REQ-025 HOLD_CYCLES=1: DRIVE lasts 1 cycle, giving 2 cycles per vector.
REQ-026 fail_mask and pass SHALL hold their values in DONE until the next start or rst.

Reset
REQ-027 rst=1 at a clock edge, including mid-run, SHALL force IDLE, a=b=0, vec_idx=0, busy=0, done=0, pass=0, fail_mask=0, err_cnt=0 and hold count 0.
REQ-028 start is ignored in any cycle where rst=1.

Configuration
REQ-029 Macro XOR_CHECK_ERRCNT_EN defined: the err_cnt port and counter exist, range 0..4, with no wrap.
REQ-030 Macro XOR_CHECK_ERRCNT_EN undefined: the err_cnt port and logic are absent; all other behaviour is identical.

Structure
REQ-031 Package xor_check_pkg SHALL hold:
- the state enum typedef (IDLE, DRIVE, SAMPLE, DONE);
- localparam NUM_VECTORS=4;
- function xor_expected(a,b).
REQ-032 The hold counter SHALL be a sub-module hold_timer, with ports clk, rst, clear, expire and parameter CYCLES.
REQ-033 fail_mask width SHALL derive from NUM_VECTORS.

Verification
REQ-034 The bench SHALL connect a, b and c to xorgate and display time, a, b, c, done and pass in tabular form.
REQ-035 Good gate, HOLD_CYCLES=2, start pulsed 1 cycle:
- a,b sequence 00,01,10,11, each held 3 cycles;
- done rises 13 cycles after start;
- pass=1, fail_mask=4'b0000, err_cnt=0.
REQ-036 Fault injection, c forced inverted during vector 2 only: fail_mask=4'b0100, pass=0, err_cnt=1.
REQ-037 c forced to 0 for the whole run: fail_mask=4'b0110, pass=0, err_cnt=2.
REQ-038 start re-pulsed during vector 1 has no effect. rst pulsed during vector 2 gives IDLE with all outputs 0 the next cycle. A new start then runs cleanly to pass=1.
REQ-039 HOLD_CYCLES=1: done rises 9 cycles after start. start in DONE restarts with fail_mask cleared one cycle later.
